vote_tally_n: RTL and testbench

Parametrised successor to the electronic ballot tallier. It counts one vote per armed ballot for up to `N_CAND` candidates, using per-candidate and total counters that saturate. On close it finds the winner with a sequential scan and flags ties. It then steps through per-candidate results one `Result` press at a time. It sits between the ballot-unit front panel (debounced, synchronised levels) and the display/readout logic.

---
 rtl/vote_pkg.sv | 10 +
 rtl/vote_tally_n_max_scan.sv | 70 +++++++
 rtl/vote_tally_n.sv | 147 ++++++++++++++
 tb/tb_vote_tally_n.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// vote_pkg: state encoding, candidate code constants and saturating increment shared by the tallier.
package vote_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, TOTAL, SCAN, CLOSED, CLEAR} vote_state_t;
  localparam int NO_VOTE = 0;
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] m;
    m = (width >= 32) ? '1 : (32'd1 << width) - 32'd1;
    return (value >= m) ? m : value + 32'd1;
  endfunction
endpackage

// File: rtl/vote_tally_n_max_scan.sv
// vote_max_scan: sequential argmax over the tally array, one entry per cycle, lowest index wins ties.
module vote_max_scan import vote_pkg::*; #(
  parameter int N  = 15,
  parameter int W  = 12,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wipe,
  input  logic          start,
  input  logic [W-1:0]  val,
  output logic [IW-1:0] idx,
  output logic [IW-1:0] winner,
  output logic          tie,
  output logic          done
);
  logic [IW-1:0] idx_q, idx_d, win_q, win_d;
  logic [W-1:0]  max_q, max_d;
  logic          busy_q, busy_d, tie_q, tie_d;
  assign idx    = idx_q;
  assign winner = win_q;
  assign tie    = tie_q;
  always_comb begin
    idx_d  = idx_q;
    win_d  = win_q;
    max_d  = max_q;
    busy_d = busy_q;
    tie_d  = tie_q;
    done   = busy_q && (idx_q == IW'(N));
    if (start) begin
      idx_d  = IW'(1);
      win_d  = IW'(NO_VOTE);
      max_d  = '0;
      tie_d  = 1'b0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      idx_d  = idx_q + IW'(1);
      busy_d = !done;
      if (val > max_q) begin
        max_d = val;
        win_d = idx_q;
        tie_d = 1'b0;
      end else if (val == max_q && max_q != '0) begin
        tie_d = 1'b1;
      end
    end
    if (wipe) begin
      idx_d  = '0;
      win_d  = IW'(NO_VOTE);
      max_d  = '0;
      busy_d = 1'b0;
      tie_d  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      win_q  <= '0;
      max_q  <= '0;
      busy_q <= 1'b0;
      tie_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      win_q  <= win_d;
      max_q  <= max_d;
      busy_q <= busy_d;
      tie_q  <= tie_d;
    end
  end
endmodule

// File: rtl/vote_tally_n.sv
// vote_tally_n: saturating per-candidate ballot tallier with sequential winner scan and stepped result readout.
module vote_tally_n import vote_pkg::*; #(
  parameter  int N_CAND = 15,
  parameter  int CNT_W  = 12,
  localparam int IDX_W  = $clog2(N_CAND + 1)
) (
  input  logic             clk,
  input  logic             Power,
  input  logic             Clear,
  input  logic             Close,
  input  logic             Ballot,
  input  logic             Total,
  input  logic             Result,
  input  logic [IDX_W-1:0] IN,
  output logic [CNT_W-1:0] out,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_vld,
  output logic             vote_ack,
  output logic             vote_rej,
  output logic [IDX_W-1:0] winner,
  output logic             tie,
  output logic             closed,
  output logic             ovf
);
  vote_state_t      state_q, state_d;
  logic [CNT_W-1:0] tally_q [N_CAND];
  logic [CNT_W-1:0] tally_d [N_CAND];
  logic [CNT_W-1:0] total_q, total_d, out_q, out_d, scan_val, pick;
  logic [IDX_W-1:0] oidx_q, oidx_d, nidx, scan_idx;
  logic             vld_q, vld_d, ack_q, ack_d, rej_q, rej_d, closed_q, closed_d, ovf_q, ovf_d;
  logic             lock_q, lock_d, res1_q, res2_q, valid, wipe, start, scan_done;
  assign out      = out_q;
  assign out_idx  = oidx_q;
  assign out_vld  = vld_q;
  assign vote_ack = ack_q;
  assign vote_rej = rej_q;
  assign closed   = closed_q;
  assign ovf      = ovf_q;
  assign wipe     = Clear || state_q == CLEAR;
  assign start    = state_q == IDLE && Close && !Clear;
  assign valid    = (IN != IDX_W'(NO_VOTE)) && (int'(IN) <= N_CAND);
  assign nidx     = (oidx_q == IDX_W'(N_CAND)) ? IDX_W'(1) : oidx_q + IDX_W'(1);
  vote_max_scan #(.N(N_CAND), .W(CNT_W), .IW(IDX_W)) u_scan (
    .clk(clk), .rst(Power), .wipe(wipe), .start(start), .val(scan_val),
    .idx(scan_idx), .winner(winner), .tie(tie), .done(scan_done)
  );
  always_comb begin
    state_d  = state_q;
    tally_d  = tally_q;
    total_d  = total_q;
    out_d    = '0;
    oidx_d   = '0;
    vld_d    = 1'b0;
    ack_d    = 1'b0;
    rej_d    = 1'b0;
    closed_d = closed_q;
    ovf_d    = ovf_q;
    lock_d   = lock_q & Ballot;
    scan_val = '0;
    pick     = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (scan_idx == IDX_W'(i + 1)) scan_val = tally_q[i];
      if (nidx == IDX_W'(i + 1)) pick = tally_q[i];
    end
    case (state_q)
      IDLE:   state_d = Close ? SCAN : (Ballot && !lock_q) ? ARMED : Total ? TOTAL : IDLE;
      ARMED: begin
        if (Close) begin
          state_d = IDLE;
        end else if (valid) begin
          for (int i = 0; i < N_CAND; i++) begin
            if (IN == IDX_W'(i + 1)) begin
              tally_d[i] = CNT_W'(sat_inc(32'(tally_q[i]), CNT_W));
              ovf_d      = ovf_q | (tally_q[i] == '1) | (total_q == '1);
            end
          end
          total_d = CNT_W'(sat_inc(32'(total_q), CNT_W));
          ack_d   = 1'b1;
          lock_d  = 1'b1;
          state_d = IDLE;
        end else begin
          rej_d = IN != IDX_W'(NO_VOTE);
        end
      end
      TOTAL:  state_d = Total ? TOTAL : IDLE;
      SCAN: begin
        state_d  = scan_done ? CLOSED : SCAN;
        closed_d = closed_q | scan_done;
      end
      CLOSED: begin
        out_d  = (res1_q && !res2_q) ? pick : out_q;
        oidx_d = (res1_q && !res2_q) ? nidx : oidx_q;
        vld_d  = vld_q | (res1_q && !res2_q);
      end
      CLEAR:  state_d = Clear ? CLEAR : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == TOTAL) begin
      out_d = total_q;
      vld_d = 1'b1;
    end
    // Clear aborts any pending vote or scan and wipes every count and readout
    if (wipe) begin
      tally_d  = '{default: '0};
      total_d  = '0;
      out_d    = '0;
      oidx_d   = '0;
      vld_d    = 1'b0;
      ack_d    = 1'b0;
      rej_d    = 1'b0;
      closed_d = 1'b0;
      ovf_d    = 1'b0;
    end
    if (Clear) state_d = CLEAR;
  end
  always_ff @(posedge clk) begin
    if (Power) begin
      state_q  <= IDLE;
      tally_q  <= '{default: '0};
      total_q  <= '0;
      out_q    <= '0;
      oidx_q   <= '0;
      vld_q    <= 1'b0;
      ack_q    <= 1'b0;
      rej_q    <= 1'b0;
      closed_q <= 1'b0;
      ovf_q    <= 1'b0;
      lock_q   <= 1'b0;
      res1_q   <= 1'b0;
      res2_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tally_q  <= tally_d;
      total_q  <= total_d;
      out_q    <= out_d;
      oidx_q   <= oidx_d;
      vld_q    <= vld_d;
      ack_q    <= ack_d;
      rej_q    <= rej_d;
      closed_q <= closed_d;
      ovf_q    <= ovf_d;
      lock_q   <= lock_d;
      res1_q   <= Result;
      res2_q   <= res1_q;
    end
  end
endmodule

// File: tb/tb_vote_tally_n.sv
// tb_vote_tally_n: randomized and directed checks of two tallier instances against a ballot-level model.
module tb_vote_tally_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0]      pw = '1, clr = '0, cls = '0, bal = '0, tot = '0, res = '0;
  logic [1:0][3:0] in_c = '0;
  logic [11:0]     out_a;
  logic [2:0]      out_b;
  logic [1:0][3:0] idx_o, win_o;
  logic [1:0]      vld_o, ack_o, rej_o, tie_o, cl_o, ovf_o;
  vote_tally_n #(.N_CAND(15), .CNT_W(12)) dut_a (
    .clk(clk), .Power(pw[0]), .Clear(clr[0]), .Close(cls[0]), .Ballot(bal[0]), .Total(tot[0]),
    .Result(res[0]), .IN(in_c[0]), .out(out_a), .out_idx(idx_o[0]), .out_vld(vld_o[0]),
    .vote_ack(ack_o[0]), .vote_rej(rej_o[0]), .winner(win_o[0]), .tie(tie_o[0]),
    .closed(cl_o[0]), .ovf(ovf_o[0])
  );
  vote_tally_n #(.N_CAND(10), .CNT_W(3)) dut_b (
    .clk(clk), .Power(pw[1]), .Clear(clr[1]), .Close(cls[1]), .Ballot(bal[1]), .Total(tot[1]),
    .Result(res[1]), .IN(in_c[1]), .out(out_b), .out_idx(idx_o[1]), .out_vld(vld_o[1]),
    .vote_ack(ack_o[1]), .vote_rej(rej_o[1]), .winner(win_o[1]), .tie(tie_o[1]),
    .closed(cl_o[1]), .ovf(ovf_o[1])
  );
  int errors = 0, checks = 0;
  int nc[2] = '{15, 10};
  int mx[2] = '{4095, 7};
  int tal[2][15];
  int tot_m[2];
  bit ovf_m[2];
  int q[$];
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int g_out(int k);
    return (k == 0) ? int'(out_a) : int'(out_b);
  endfunction
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic model_clear(int k);
    for (int i = 0; i < 15; i++) tal[k][i] = 0;
    tot_m[k] = 0;
    ovf_m[k] = 0;
  endtask
  task automatic vote_m(int k, int c);
    if (tal[k][c-1] == mx[k] || tot_m[k] == mx[k]) ovf_m[k] = 1;
    if (tal[k][c-1] < mx[k]) tal[k][c-1]++;
    if (tot_m[k] < mx[k]) tot_m[k]++;
  endtask
  task automatic chk_idle_outs(int k, string tag);
    check({tag, "_out"}, g_out(k), 0);
    check({tag, "_idx"}, int'(idx_o[k]), 0);
    check({tag, "_vld"}, int'(vld_o[k]), 0);
    check({tag, "_closed"}, int'(cl_o[k]), 0);
    check({tag, "_winner"}, int'(win_o[k]), 0);
    check({tag, "_tie"}, int'(tie_o[k]), 0);
    check({tag, "_ovf"}, int'(ovf_o[k]), 0);
  endtask
  task automatic cast(int k, int c, int f);
    bal[k] = 1'b1;
    in_c[k] = 4'(c);
    tick(2);
    if (c >= 1 && c <= nc[k]) begin
      check("ack", int'(ack_o[k]), 1);
      check("rej", int'(rej_o[k]), 0);
      vote_m(k, c);
    end else begin
      check("ack_wait", int'(ack_o[k]), 0);
      check("rej_pulse", int'(rej_o[k]), (c != 0) ? 1 : 0);
      in_c[k] = 4'(f);
      tick(1);
      check("ack_retry", int'(ack_o[k]), 1);
      check("rej_end", int'(rej_o[k]), 0);
      vote_m(k, f);
    end
    check("ovf", int'(ovf_o[k]), int'(ovf_m[k]));
    bal[k] = 1'b0;
    in_c[k] = '0;
    tick(1);
    check("ack_one_cycle", int'(ack_o[k]), 0);
  endtask
  task automatic show_total(int k);
    tot[k] = 1'b1;
    tick(2);
    check("total_out", g_out(k), tot_m[k]);
    check("total_vld", int'(vld_o[k]), 1);
    check("total_idx", int'(idx_o[k]), 0);
    tot[k] = 1'b0;
    tick(1);
    check("total_off_vld", int'(vld_o[k]), 0);
    check("total_off_out", g_out(k), 0);
  endtask
  task automatic chk_winner(int k);
    int best, w, n;
    best = 0;
    w = 0;
    n = 0;
    for (int i = 0; i < nc[k]; i++) if (tal[k][i] > best) begin best = tal[k][i]; w = i + 1; end
    for (int i = 0; i < nc[k]; i++) if (best > 0 && tal[k][i] == best) n++;
    check("winner", int'(win_o[k]), w);
    check("tie", int'(tie_o[k]), (n > 1) ? 1 : 0);
  endtask
  task automatic wait_closed(int k, int n0, int exp);
    int n;
    n = n0;
    while (!cl_o[k] && n < 300) begin
      tick(1);
      n++;
    end
    cls[k] = 1'b0;
    check("close_latency", n, exp);
    chk_winner(k);
  endtask
  task automatic results(int k, int presses);
    int r;
    r = 0;
    repeat (presses) begin
      res[k] = 1'b1;
      tick(2);
      r = (r == nc[k]) ? 1 : r + 1;
      check("res_idx", int'(idx_o[k]), r);
      check("res_out", g_out(k), tal[k][r-1]);
      check("res_vld", int'(vld_o[k]), 1);
      tick($urandom_range(0, 2));
      check("res_held", int'(idx_o[k]), r);
      res[k] = 1'b0;
      tick(1);
    end
    bal[k] = 1'b1;
    tot[k] = 1'b1;
    tick(2);
    check("closed_ign_ack", int'(ack_o[k]), 0);
    check("closed_ign_idx", int'(idx_o[k]), r);
    check("closed_stays", int'(cl_o[k]), 1);
    bal[k] = 1'b0;
    tot[k] = 1'b0;
  endtask
  task automatic clear_chk(int k);
    clr[k] = 1'b1;
    tick(1);
    chk_idle_outs(k, "clear");
    tick(1);
    clr[k] = 1'b0;
    tick(1);
    model_clear(k);
  endtask
  task automatic session(int k, int presses);
    foreach (q[i]) cast(k, q[i], $urandom_range(1, nc[k]));
    q.delete();
    show_total(k);
    cls[k] = 1'b1;
    wait_closed(k, 0, nc[k] + 1);
    results(k, presses);
    clear_chk(k);
  endtask
  task automatic add(int c, int n);
    repeat (n) q.push_back(c);
  endtask
  initial begin
    model_clear(0);
    model_clear(1);
    tick(1);
    pw = '0;
    chk_idle_outs(0, "reset_a");
    chk_idle_outs(1, "reset_b");
    check("reset_ack", int'(ack_o), 0);
    add(2, 3); add(7, 5); add(15, 1);
    session(0, 17);
    bal[0] = 1'b1;
    in_c[0] = 4'd5;
    tick(2);
    check("hold_ack", int'(ack_o[0]), 1);
    vote_m(0, 5);
    repeat (3) begin
      tick(1);
      check("hold_no_rearm", int'(ack_o[0]), 0);
    end
    bal[0] = 1'b0;
    in_c[0] = '0;
    tick(1);
    for (int i = 0; i < 20; i++) add($urandom_range(0, 15), 1);
    session(0, 5);
    add(3, 4); add(9, 4);
    session(0, 3);
    session(0, 2);
    cast(0, 6, 1); cast(0, 6, 1);
    cls[0] = 1'b1;
    tick(3);
    cls[0] = 1'b0;
    clr[0] = 1'b1;
    tick(1);
    check("scan_abort_closed", int'(cl_o[0]), 0);
    tick(20);
    check("scan_abort_hold", int'(cl_o[0]), 0);
    clr[0] = 1'b0;
    tick(1);
    model_clear(0);
    cast(0, 11, 1);
    show_total(0);
    bal[0] = 1'b1;
    tick(1);
    cls[0] = 1'b1;
    in_c[0] = 4'd4;
    tick(1);
    check("armed_cancel_ack", int'(ack_o[0]), 0);
    bal[0] = 1'b0;
    in_c[0] = '0;
    wait_closed(0, 1, nc[0] + 2);
    results(0, 3);
    clear_chk(0);
    cast(1, 12, 4);
    session(1, 3);
    add(1, 9);
    session(1, 2);
    for (int i = 0; i < 25; i++) add($urandom_range(0, 15), 1);
    session(1, 12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
